// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: loader state encoding, datapath widths, initial hash values
// and the word-address helper used by the host-side message loader.
package sha1_pkg;

  localparam int SHA1_DIGEST_W = 160;
  localparam int SHA1_WORD_W   = 32;

  localparam logic [SHA1_WORD_W-1:0] SHA1_H0 = 32'h67452301;
  localparam logic [SHA1_WORD_W-1:0] SHA1_H1 = 32'hEFCDAB89;
  localparam logic [SHA1_WORD_W-1:0] SHA1_H2 = 32'h98BADCFE;
  localparam logic [SHA1_WORD_W-1:0] SHA1_H3 = 32'h10325476;
  localparam logic [SHA1_WORD_W-1:0] SHA1_H4 = 32'hC3D2E1F0;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FLUSH,
    KICK,
    WLO,
    WHI,
    OUT
  } ldr_state_t;

  // Byte address of the word holding message byte idx; wraps within 16 bits.
  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] idx);
    return base + {idx[15:2], 2'b00};
  endfunction

endpackage

// File: rtl/sha1_byte_packer.sv
// Packs accepted message bytes little-endian into 32-bit words and issues one registered
// dpsram write per completed word, or per partial final word with its upper bytes zeroed.
module sha1_byte_packer
  import sha1_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   byte_en,
  input  logic                   byte_discard,
  input  logic                   byte_last,
  input  logic [7:0]             byte_data,
  input  logic [15:0]            byte_idx,
  output logic                   mem_we,
  output logic [15:0]            mem_addr,
  output logic [SHA1_WORD_W-1:0] mem_data
);

  logic [SHA1_WORD_W-1:0] pack_q, pack_d;
  logic [SHA1_WORD_W-1:0] word_ins;
  logic                   we_q, we_d;
  logic [15:0]            addr_q, addr_d;
  logic [SHA1_WORD_W-1:0] data_q, data_d;

  always_comb begin
    word_ins = pack_q;
    for (int l = 0; l < 4; l++) begin
      if (byte_idx[1:0] == l[1:0]) word_ins[8*l +: 8] = byte_data;
    end

    pack_d = pack_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (byte_en) begin
      if (byte_discard) begin
        // Overflowing bytes never reach memory; drop any half-built word with them.
        pack_d = '0;
      end else if (byte_idx[1:0] == 2'd3 || byte_last) begin
        we_d   = 1'b1;
        addr_d = word_addr(BASE_ADDR, byte_idx);
        data_d = word_ins;
        pack_d = '0;
      end else begin
        pack_d = word_ins;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pack_q <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      pack_q <= pack_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;

endmodule

// File: rtl/sha1_msg_loader.sv
// Host-side SHA-1 loader: streams a message into dpsram, kicks the hash engine, waits for
// a fresh done and returns the captured digest on a valid/ready output.
module sha1_msg_loader
  import sha1_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_BYTES = 16384
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     mem_clk,
  output logic [15:0]              mem_addr,
  output logic                     mem_we,
  output logic [SHA1_WORD_W-1:0]   mem_data_in,
  output logic                     hash_start,
  output logic [31:0]              hash_msg_addr,
  output logic [31:0]              hash_msg_size,
  input  logic                     hash_done,
  input  logic [SHA1_DIGEST_W-1:0] hash_in,
  output logic                     digest_valid,
  output logic [SHA1_DIGEST_W-1:0] digest,
  input  logic                     digest_ready,
  output logic                     busy,
  output logic                     err
);

  if (MAX_BYTES == 0 || MAX_BYTES > 65535) begin : g_bad_max_bytes
    $error("sha1_msg_loader: MAX_BYTES must be in 1..65535");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base_addr
    $error("sha1_msg_loader: BASE_ADDR must be 4-byte aligned");
  end

  ldr_state_t               state_q, state_d;
  logic [31:0]              count_q, count_d;
  logic                     err_q, err_d;
  logic                     s_ready_q, s_ready_d;
  logic                     busy_q, busy_d;
  logic                     start_q, start_d;
  logic [31:0]              size_q, size_d;
  logic                     dv_q, dv_d;
  logic [SHA1_DIGEST_W-1:0] digest_q, digest_d;

  logic        byte_acc;
  logic        byte_discard;
  logic [15:0] byte_idx;

  assign byte_acc     = s_valid && s_ready_q;
  assign byte_idx     = (state_q == IDLE) ? 16'd0 : count_q[15:0];
  // Once the limit is hit the rest of the message is swallowed up to s_last.
  assign byte_discard = (state_q == FILL) && (err_q || count_q == MAX_BYTES);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_d    = err_q;
    size_d   = size_q;
    dv_d     = dv_q;
    digest_d = digest_q;

    case (state_q)
      IDLE: begin
        if (byte_acc) begin
          count_d = 32'd1;
          err_d   = 1'b0;
          state_d = s_last ? FLUSH : FILL;
        end
      end
      FILL: begin
        if (byte_acc) begin
          if (byte_discard) begin
            err_d = 1'b1;
            if (s_last) state_d = IDLE;
          end else begin
            count_d = count_q + 32'd1;
            if (s_last) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        size_d  = count_q;
        state_d = KICK;
      end
      KICK: state_d = WLO;
      // done is still high from the previous hash; only a fresh rise is trusted.
      WLO: begin
        if (!hash_done) state_d = WHI;
      end
      WHI: begin
        if (hash_done) begin
          digest_d = hash_in;
          dv_d     = 1'b1;
          state_d  = OUT;
        end
      end
      OUT: begin
        if (digest_ready) begin
          dv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == IDLE) || (state_d == FILL);
    busy_d    = (state_d != IDLE);
    start_d   = (state_d == KICK) && (state_q != KICK);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      err_q     <= 1'b0;
      s_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      size_q    <= '0;
      dv_q      <= 1'b0;
      digest_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      err_q     <= err_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      size_q    <= size_d;
      dv_q      <= dv_d;
      digest_q  <= digest_d;
    end
  end

  sha1_byte_packer #(
    .BASE_ADDR (BASE_ADDR)
  ) u_packer (
    .clk          (clk),
    .nreset       (nreset),
    .byte_en      (byte_acc),
    .byte_discard (byte_discard),
    .byte_last    (s_last),
    .byte_data    (s_data),
    .byte_idx     (byte_idx),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data_in)
  );

  assign mem_clk       = clk;
  assign s_ready       = s_ready_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign hash_start    = start_q;
  assign hash_msg_addr = {16'h0000, BASE_ADDR};
  assign hash_msg_size = size_q;
  assign digest_valid  = dv_q;
  assign digest        = digest_q;

endmodule

// File: tb/tb_sha1_msg_loader.sv
// Scoreboard bench for sha1_msg_loader with a behavioural SHA-1 engine reading an SRAM model.
module tb_sha1_msg_loader;
  import sha1_pkg::*;

  localparam logic [15:0] BASE = 16'h0040;
  localparam int          MAXB = 8;
  localparam logic [159:0] ABC_DIG = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         nreset;
  logic         s_valid, s_last, s_ready;
  logic [7:0]   s_data;
  logic         mem_clk, mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_data_in;
  logic         hash_start, hash_done;
  logic [31:0]  hash_msg_addr, hash_msg_size;
  logic [159:0] hash_in, digest;
  logic         digest_valid, digest_ready, busy, err;

  sha1_msg_loader #(
    .BASE_ADDR (BASE),
    .MAX_BYTES (MAXB)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .mem_clk       (mem_clk),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_data_in   (mem_data_in),
    .hash_start    (hash_start),
    .hash_msg_addr (hash_msg_addr),
    .hash_msg_size (hash_msg_size),
    .hash_done     (hash_done),
    .hash_in       (hash_in),
    .digest_valid  (digest_valid),
    .digest        (digest),
    .digest_ready  (digest_ready),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  wr_t          wq[$];
  logic [31:0]  sq[$];
  logic [159:0] dq[$];
  logic [31:0]  sram [0:16383];
  int  hold_n   = 0;
  int  drop_dly = 2;
  int  calc_dly = 5;
  bit  eng_redone = 1'b0;
  logic [31:0] last_size = '0;

  task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic [159:0] sha1_model(input bq_t msg);
    bq_t         m;
    logic [31:0] w[80];
    logic [31:0] h[5];
    logic [31:0] a, b, c, d, e, f, k, t;
    logic [63:0] bl;
    m  = msg;
    bl = 64'(msg.size()) * 64'd8;
    m.push_back(8'h80);
    while ((m.size() % 64) != 56) m.push_back(8'h00);
    for (int i = 7; i >= 0; i--) m.push_back(bl[8*i +: 8]);
    h[0] = SHA1_H0; h[1] = SHA1_H1; h[2] = SHA1_H2; h[3] = SHA1_H3; h[4] = SHA1_H4;
    for (int blk = 0; blk < m.size() / 64; blk++) begin
      for (int j = 0; j < 16; j++)
        w[j] = {m[64*blk+4*j], m[64*blk+4*j+1], m[64*blk+4*j+2], m[64*blk+4*j+3]};
      for (int j = 16; j < 80; j++) begin
        t    = w[j-3] ^ w[j-8] ^ w[j-14] ^ w[j-16];
        w[j] = {t[30:0], t[31]};
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
      for (int j = 0; j < 80; j++) begin
        if (j < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
        else if (j < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
        else if (j < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
        else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
        t = {a[26:0], a[31:27]} + f + e + k + w[j];
        e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e;
    end
    return {h[0], h[1], h[2], h[3], h[4]};
  endfunction

  always @(posedge clk) if (mem_we) sram[mem_addr[15:2]] <= mem_data_in;

  // Engine: done stays high after a hash, falls some cycles after start, rises with the digest.
  initial begin
    bq_t         eb;
    logic [31:0] esz, wv;
    logic [15:0] ebase;
    int          ea;
    hash_done = 1'b1;
    hash_in   = '0;
    forever begin
      @(posedge clk);
      if (nreset && hash_start) begin
        esz        = hash_msg_size;
        ebase      = hash_msg_addr[15:0];
        eng_redone = 1'b0;
        repeat (drop_dly) @(posedge clk);
        #1;
        hash_done = 1'b0;
        hash_in   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        repeat (calc_dly) @(posedge clk);
        #1;
        eb.delete();
        for (int i = 0; i < int'(esz); i++) begin
          ea = int'(ebase) + i;
          wv = sram[(ea >> 2) & 16383];
          eb.push_back(wv[8*(ea%4) +: 8]);
        end
        hash_in    = sha1_model(eb);
        hash_done  = 1'b1;
        eng_redone = 1'b1;
      end
    end
  end

  // Monitor: writes and start pulses against the scoreboard queues.
  initial begin
    bit   start_prev = 1'b0;
    bit   dv_prev    = 1'b0;
    wr_t  ew;
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (mem_we) begin
          check_val("wr_pending", 160'(wq.size() > 0), 160'd1);
          if (wq.size() > 0) begin
            ew = wq.pop_front();
            check_val("wr_addr", 160'(mem_addr), 160'(ew.addr));
            check_val("wr_data", 160'(mem_data_in), 160'(ew.data));
          end
        end
        if (hash_start) begin
          check_val("start_1cyc", 160'(start_prev), 160'd0);
          check_val("start_pending", 160'(sq.size() > 0), 160'd1);
          check_val("msg_addr", 160'(hash_msg_addr), {128'd0, 16'h0000, BASE});
          if (sq.size() > 0) begin
            last_size = sq.pop_front();
            check_val("msg_size", 160'(hash_msg_size), 160'(last_size));
          end
        end
        if (digest_valid && !dv_prev) check_val("cap_after_redone", 160'(eng_redone), 160'd1);
        start_prev = hash_start;
        dv_prev    = digest_valid;
      end else begin
        start_prev = 1'b0;
        dv_prev    = 1'b0;
      end
    end
  end

  // Consumer: optionally stalls, then takes the digest and checks it.
  initial begin
    logic [159:0] snap;
    digest_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (nreset && digest_valid) begin
        snap = digest;
        for (int i = 0; i < hold_n; i++) begin
          @(negedge clk);
          check_val("dig_stable", digest, snap);
          check_val("dv_hold", 160'(digest_valid), 160'd1);
          check_val("s_ready_out", 160'(s_ready), 160'd0);
        end
        digest_ready = 1'b1;
        check_val("dig_pending", 160'(dq.size() > 0), 160'd1);
        if (dq.size() > 0) check_val("digest", digest, dq.pop_front());
        check_val("size_hold", 160'(hash_msg_size), 160'(last_size));
        @(negedge clk);
        digest_ready = 1'b0;
        check_val("dv_drop", 160'(digest_valid), 160'd0);
      end
    end
  end

  task automatic send_msg(input bq_t b, input bit last_flag, input logic [159:0] ref_dig,
                          input bit use_ref);
    logic [31:0] word = '0;
    wr_t         ew;
    int          w;
    @(negedge clk);
    for (int i = 0; i < b.size(); i++) begin
      s_valid = 1'b1;
      s_data  = b[i];
      s_last  = last_flag && (i == b.size() - 1);
      w = 0;
      while (!s_ready && w < 3000) begin
        @(negedge clk);
        w++;
      end
      if (!s_ready) begin
        check_val("s_ready_wait", 160'(s_ready), 160'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(posedge clk);
      if (i < MAXB) begin
        word[8*(i%4) +: 8] = b[i];
        if ((i % 4) == 3 || s_last) begin
          ew.addr = BASE + 16'(4 * (i / 4));
          ew.data = word;
          wq.push_back(ew);
          word = '0;
        end
      end
      @(negedge clk);
      check_val("err", 160'(err), 160'(i >= MAXB));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (last_flag && b.size() <= MAXB) begin
      sq.push_back(32'(b.size()));
      dq.push_back(use_ref ? ref_dig : sha1_model(b));
    end
    if (last_flag && b.size() > MAXB) begin
      check_val("ovf_idle_busy", 160'(busy), 160'd0);
      check_val("ovf_idle_ready", 160'(s_ready), 160'd1);
    end
  endtask

  task automatic wait_done();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((busy || dq.size() > 0 || digest_valid) && w < 3000);
    check_val("done_busy", 160'(busy), 160'd0);
    check_val("done_dq", 160'(dq.size()), 160'd0);
  endtask

  task automatic check_reset();
    check_val("rst_s_ready", 160'(s_ready), 160'd1);
    check_val("rst_busy", 160'(busy), 160'd0);
    check_val("rst_mem_we", 160'(mem_we), 160'd0);
    check_val("rst_mem_addr", 160'(mem_addr), 160'd0);
    check_val("rst_mem_data", 160'(mem_data_in), 160'd0);
    check_val("rst_start", 160'(hash_start), 160'd0);
    check_val("rst_size", 160'(hash_msg_size), 160'd0);
    check_val("rst_msg_addr", 160'(hash_msg_addr), {128'd0, 16'h0000, BASE});
    check_val("rst_dv", 160'(digest_valid), 160'd0);
    check_val("rst_digest", digest, 160'd0);
    check_val("rst_err", 160'(err), 160'd0);
  endtask

  initial begin
    bq_t rq;
    nreset  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    nreset = 1'b1;

    // "abc" then "abcd" queued straight behind it; the second waits through OUT.
    send_msg(str2q("abc"), 1'b1, ABC_DIG, 1'b1);
    send_msg(str2q("abcd"), 1'b1, '0, 1'b0);
    wait_done();

    hold_n = 1;
    send_msg(str2q("abcde"), 1'b1, '0, 1'b0);
    wait_done();

    // Slow done drop and a stalled consumer.
    drop_dly = 6;
    hold_n   = 10;
    send_msg(str2q("xyz"), 1'b1, '0, 1'b0);
    wait_done();
    drop_dly = 2;
    hold_n   = 0;

    // Exactly MAX_BYTES, then an overflowing message, then a single-byte message.
    send_msg(str2q("abcdefgh"), 1'b1, '0, 1'b0);
    wait_done();
    send_msg(str2q("0123456789"), 1'b1, '0, 1'b0);
    wait_done();
    send_msg(str2q("q"), 1'b1, '0, 1'b0);
    wait_done();

    for (int r = 0; r < 4; r++) begin
      rq.delete();
      for (int i = 0; i < int'($urandom_range(1, MAXB)); i++)
        rq.push_back(8'($urandom_range(32, 126)));
      hold_n = r;
      send_msg(rq, 1'b1, '0, 1'b0);
      wait_done();
    end
    hold_n = 0;

    // Abandon a message mid-fill with reset, then hash afresh.
    send_msg(str2q("abcdef"), 1'b0, '0, 1'b0);
    nreset = 1'b0;
    #1;
    check_reset();
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    send_msg(str2q("abc"), 1'b1, ABC_DIG, 1'b1);
    wait_done();

    check_val("wq_drained", 160'(wq.size()), 160'd0);
    check_val("sq_drained", 160'(sq.size()), 160'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
